mef_vedacao: RTL and testbench
==============================

Name: mef_vedacao

Overview:
- Sealing-station controller; responder to the main filling FSM's vedação request (pos_ve), returning ve_done.
- Per bottle it dispenses one cap, lowers the capping piston, holds it, raises it, then signals completion.
- Tracks cap stock, raises an alarm when the stock is empty and accepts operator reload.

Parameters:
- CAP_W, 5, width of the cap-stock counter.
- CAP_MAX, 20, stock value loaded by reload; must be ≤ 2^CAP_W-1.
- DOWN_CYCLES, 4, clock cycles spent in DOWN (≥1).
- HOLD_CYCLES, 8, clock cycles spent in HOLD (≥1).
- UP_CYCLES, 4, clock cycles spent in UP (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pos_ve  in  1  sealing request; level, held high by the main FSM until it sees ve_done.
- reload  in  1  operator cap reload; level sampled each cycle.
- ve_done  out  1  one-cycle completion pulse.
- dispensa  out  1  cap-feeder strobe.
- pistao  out  1  piston down command.
- estoque  out  CAP_W  current cap count.
- alarme  out  1  cap stock empty while a request is pending.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timer=0, estoque=CAP_MAX. All 1-bit outputs are 0.
- Outputs are Moore decodes of the state:
  - dispensa=(FEED)
  - pistao=(DOWN|HOLD)
  - ve_done=(DONE)
  - alarme=(EMPTY)
- States: IDLE, FEED, DOWN, HOLD, UP, DONE, WREL, EMPTY.
- IDLE:
  - pos_ve=1 and estoque≠0 → FEED.
  - pos_ve=1 and estoque=0 → EMPTY.
  - Otherwise stay.
- FEED: one cycle; estoque decrements by 1 on exit → DOWN.
- DOWN, HOLD, UP each last exactly their parameter count of cycles.
  - Timer clears on state entry and counts to N-1.
  - Sequence: DOWN → HOLD → UP → DONE.
- DONE: one cycle; ve_done=1 → WREL.
- WREL: wait for pos_ve=0 → IDLE. This prevents re-sealing the same bottle.
- Latency: pos_ve sampled high in IDLE on edge 0 → ve_done high during cycle 2+DOWN+HOLD+UP (18 with defaults).
- Abort: pos_ve=0 during DOWN or HOLD → UP for full UP_CYCLES, then IDLE. No ve_done is issued and the cap is not refunded.
- pos_ve=0 during FEED or UP: no effect; the sequence continues. If pos_ve is still 0 on reaching DONE, ve_done is suppressed and the FSM goes to IDLE.
- EMPTY: alarme=1. reload=1 → estoque=CAP_MAX → IDLE; the sequence restarts if pos_ve is still high.
- reload in any state loads estoque=CAP_MAX next edge. Reload has priority over the FEED decrement.
- estoque never wraps below 0; FEED is unreachable with estoque=0.
- Illegal state encodings → IDLE.

Optional Feature:
- Macro: CAP_SENSOR_EN.
- Defined:
  - Adds input tampa_ok (1 bit) and output falha_ved (1 bit, reset 0).
  - tampa_ok is sampled on the last HOLD cycle.
  - On a failed check, the FSM goes through UP and retries once from FEED, consuming another cap. If estoque=0 at retry, it goes to DONE directly.
  - On a second failure, DONE asserts ve_done and falha_ved together for one cycle, so quality control discards the bottle.
  - Latency on success is unchanged.
- Undefined: the ports are absent; no check or retry is performed.

Test Plan:
- Reset, then hold pos_ve=1 with defaults → dispensa at cycle 1, pistao high for 12 cycles, ve_done single pulse at cycle 18, estoque=19.
- Hold pos_ve high after ve_done for 5 cycles → no second FEED; drop pos_ve → IDLE; a new request yields ve_done again, estoque=18.
- Drop pos_ve during HOLD cycle 3 → pistao falls, UP runs 4 cycles, no ve_done, estoque=19.
- Run 20 sealings, then request → alarme=1, no dispensa; pulse reload → estoque=20, alarme=0, sealing completes with estoque=19.
- Assert reset=0 mid-DOWN → pistao=0, estoque=20, state IDLE immediately without waiting for clk.
- With CAP_SENSOR_EN and tampa_ok=0 twice → two dispensa strobes, ve_done and falha_ved high together, estoque=18.

Source files
------------

// File: rtl/mef_vedacao_if.sv
// Sealing-station bus: request/completion handshake, operator reload and actuator/status lines.
// Optional macro CAP_SENSOR_EN adds the cap-presence input and the sealing-failure flag.
interface mef_vedacao_if #(
    parameter int CAP_W = 5
);
    logic             pos_ve;
    logic             reload;
    logic             ve_done;
    logic             dispensa;
    logic             pistao;
    logic [CAP_W-1:0] estoque;
    logic             alarme;
`ifdef CAP_SENSOR_EN
    logic             tampa_ok;
    logic             falha_ved;

    modport master (
        output pos_ve, reload, tampa_ok,
        input  ve_done, dispensa, pistao, estoque, alarme, falha_ved
    );
    modport slave (
        input  pos_ve, reload, tampa_ok,
        output ve_done, dispensa, pistao, estoque, alarme, falha_ved
    );
`else
    modport master (
        output pos_ve, reload,
        input  ve_done, dispensa, pistao, estoque, alarme
    );
    modport slave (
        input  pos_ve, reload,
        output ve_done, dispensa, pistao, estoque, alarme
    );
`endif
endinterface

// File: rtl/mef_vedacao.sv
// Sealing-station controller: dispense cap, lower/hold/raise piston, report ve_done, track cap stock.
// Optional macro CAP_SENSOR_EN: checks tampa_ok on the last HOLD cycle, retries once, flags falha_ved.
module mef_vedacao #(
    parameter int CAP_W       = 5,
    parameter int CAP_MAX     = 20,
    parameter int DOWN_CYCLES = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int UP_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         reset,
    mef_vedacao_if.slave bus
);
    localparam int T_MAX = (DOWN_CYCLES > HOLD_CYCLES)
                         ? ((DOWN_CYCLES > UP_CYCLES) ? DOWN_CYCLES : UP_CYCLES)
                         : ((HOLD_CYCLES > UP_CYCLES) ? HOLD_CYCLES : UP_CYCLES);
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0] DOWN_LAST  = TMR_W'(DOWN_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] UP_LAST    = TMR_W'(UP_CYCLES - 1);
    localparam logic [CAP_W-1:0] STOCK_FULL = CAP_W'(CAP_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DOWN  = 3'd2,
        HOLD  = 3'd3,
        UP    = 3'd4,
        DONE  = 3'd5,
        WREL  = 3'd6,
        EMPTY = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CAP_W-1:0] estoque_q, estoque_d;
    logic             abort_q, abort_d;
    logic             dispensa_q, pistao_q, ve_done_q, alarme_q;
`ifdef CAP_SENSOR_EN
    logic             fail_q, fail_d;
    logic             retry_q, retry_d;
    logic             bad_q, bad_d;
    logic             falha_ved_q;
`endif

    // Next-state, dwell timer and cap-stock bookkeeping.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TMR_W'(1);
        abort_d   = abort_q;
        estoque_d = estoque_q;
`ifdef CAP_SENSOR_EN
        fail_d    = fail_q;
        retry_d   = retry_q;
        bad_d     = bad_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.pos_ve) begin
                    if (estoque_q != '0) begin
                        state_d = FEED;
`ifdef CAP_SENSOR_EN
                        fail_d  = 1'b0;
                        retry_d = 1'b0;
                        bad_d   = 1'b0;
`endif
                    end else begin
                        state_d = EMPTY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FEED: begin
                timer_d = '0;
                abort_d = 1'b0;
                state_d = DOWN;
                if (estoque_q != '0) begin
                    estoque_d = estoque_q - CAP_W'(1);
                end else begin
                    estoque_d = estoque_q;
                end
            end
            DOWN: begin
                if (!bus.pos_ve) begin
                    state_d = UP;
                    timer_d = '0;
                    abort_d = 1'b1;
                end else if (timer_q == DOWN_LAST) begin
                    state_d = HOLD;
                    timer_d = '0;
                end else begin
                    state_d = DOWN;
                end
            end
            HOLD: begin
                if (!bus.pos_ve) begin
                    state_d = UP;
                    timer_d = '0;
                    abort_d = 1'b1;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = UP;
                    timer_d = '0;
`ifdef CAP_SENSOR_EN
                    if (!bus.tampa_ok) begin
                        if (retry_q) begin
                            bad_d = 1'b1;
                        end else begin
                            fail_d = 1'b1;
                        end
                    end else begin
                        fail_d = fail_q;
                    end
`endif
                end else begin
                    state_d = HOLD;
                end
            end
            UP: begin
                if (timer_q == UP_LAST) begin
                    timer_d = '0;
                    // A dropped request by the end of UP means the bottle is gone: no ve_done.
                    if (abort_q || !bus.pos_ve) begin
                        state_d = IDLE;
`ifdef CAP_SENSOR_EN
                    end else if (fail_q) begin
                        fail_d  = 1'b0;
                        retry_d = 1'b1;
                        if (estoque_q != '0) begin
                            state_d = FEED;
                        end else begin
                            state_d = DONE;
                            bad_d   = 1'b1;
                        end
`endif
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = UP;
                end
            end
            DONE: begin
                timer_d = '0;
                state_d = WREL;
            end
            WREL: begin
                timer_d = '0;
                if (!bus.pos_ve) begin
                    state_d = IDLE;
                end else begin
                    state_d = WREL;
                end
            end
            EMPTY: begin
                timer_d = '0;
                if (bus.reload || !bus.pos_ve) begin
                    state_d = IDLE;
                end else begin
                    state_d = EMPTY;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
        if (bus.reload) begin
            estoque_d = STOCK_FULL;
        end else begin
            estoque_d = estoque_d;
        end
    end

    // State registers; outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            estoque_q   <= STOCK_FULL;
            abort_q     <= 1'b0;
            dispensa_q  <= 1'b0;
            pistao_q    <= 1'b0;
            ve_done_q   <= 1'b0;
            alarme_q    <= 1'b0;
`ifdef CAP_SENSOR_EN
            fail_q      <= 1'b0;
            retry_q     <= 1'b0;
            bad_q       <= 1'b0;
            falha_ved_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            estoque_q   <= estoque_d;
            abort_q     <= abort_d;
            dispensa_q  <= (state_d == FEED);
            pistao_q    <= (state_d == DOWN) || (state_d == HOLD);
            ve_done_q   <= (state_d == DONE);
            alarme_q    <= (state_d == EMPTY);
`ifdef CAP_SENSOR_EN
            fail_q      <= fail_d;
            retry_q     <= retry_d;
            bad_q       <= bad_d;
            falha_ved_q <= (state_d == DONE) && bad_d;
`endif
        end
    end

    assign bus.dispensa  = dispensa_q;
    assign bus.pistao    = pistao_q;
    assign bus.ve_done   = ve_done_q;
    assign bus.alarme    = alarme_q;
    assign bus.estoque   = estoque_q;
`ifdef CAP_SENSOR_EN
    assign bus.falha_ved = falha_ved_q;
`endif
endmodule

// File: tb/tb_mef_vedacao.sv
// Self-checking bench for mef_vedacao: directed test-plan scenarios plus randomized requests,
// compared every cycle against a timeline model of the sealing sequence.
module tb_mef_vedacao;
    localparam int CAP_W   = 5;
    localparam int CAP_MAX = 20;
    localparam int D       = 4;
    localparam int H       = 8;
    localparam int U       = 4;
    localparam int T_DONE  = D + H + U + 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mef_vedacao_if #(.CAP_W(CAP_W)) bus_if ();

    mef_vedacao #(
        .CAP_W(CAP_W), .CAP_MAX(CAP_MAX),
        .DOWN_CYCLES(D), .HOLD_CYCLES(H), .UP_CYCLES(U)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_run = cycles since FEED entry (-1 when no sealing is running).
    int m_run, m_abort, m_stock;
    bit m_wrel, m_empty;
    bit m_fail, m_retried, m_bad;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = -1; m_abort = -1; m_stock = CAP_MAX;
        m_wrel = 1'b0; m_empty = 1'b0;
        m_fail = 1'b0; m_retried = 1'b0; m_bad = 1'b0;
    endtask

    task automatic model_edge();
        bit pos, rel, dec, tampa;
        pos   = bus_if.pos_ve;
        rel   = bus_if.reload;
        dec   = (m_run == 0);
        tampa = 1'b1;
`ifdef CAP_SENSOR_EN
        tampa = bus_if.tampa_ok;
`endif
        if (m_run >= 0) begin
            if (m_run >= 1 && m_run <= D + H && !pos) begin
                m_run = -1; m_abort = 0;
            end else if (m_run == D + H + U) begin
                if (!pos) m_run = -1;
                else if (m_fail) begin
                    m_fail = 1'b0; m_retried = 1'b1;
                    if (m_stock != 0) m_run = 0;
                    else begin m_run = T_DONE; m_bad = 1'b1; end
                end else m_run = T_DONE;
            end else if (m_run == T_DONE) begin
                m_run = -1; m_wrel = 1'b1;
            end else begin
                if (m_run == D + H && !tampa) begin
                    if (m_retried) m_bad = 1'b1;
                    else m_fail = 1'b1;
                end
                m_run++;
            end
        end else if (m_abort >= 0) begin
            if (m_abort == U - 1) m_abort = -1;
            else m_abort++;
        end else if (m_wrel) begin
            if (!pos) m_wrel = 1'b0;
        end else if (m_empty) begin
            if (rel || !pos) m_empty = 1'b0;
        end else if (pos) begin
            if (m_stock != 0) begin
                m_run = 0; m_fail = 1'b0; m_retried = 1'b0; m_bad = 1'b0;
            end else m_empty = 1'b1;
        end
        if (rel) m_stock = CAP_MAX;
        else if (dec) m_stock--;
    endtask

    task automatic check_outputs();
        check_val("dispensa", int'(bus_if.dispensa), int'(m_run == 0));
        check_val("pistao",   int'(bus_if.pistao),   int'(m_run >= 1 && m_run <= D + H));
        check_val("ve_done",  int'(bus_if.ve_done),  int'(m_run == T_DONE));
        check_val("alarme",   int'(bus_if.alarme),   int'(m_empty));
        check_val("estoque",  int'(bus_if.estoque),  m_stock);
`ifdef CAP_SENSOR_EN
        check_val("falha_ved", int'(bus_if.falha_ved), int'(m_run == T_DONE && m_bad));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic request(input int hold, input int gap, input bit rnd);
        bus_if.pos_ve = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (rnd) begin
                bus_if.reload = ($urandom_range(0, 29) == 0);
`ifdef CAP_SENSOR_EN
                bus_if.tampa_ok = ($urandom_range(0, 3) != 0);
`endif
            end
            step();
        end
        bus_if.pos_ve = 1'b0;
        bus_if.reload = 1'b0;
        for (int i = 0; i < gap; i++) step();
    endtask

    initial begin
        int done_cyc, pist_cnt, disp_cnt;
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b0;
        bus_if.pos_ve = 1'b0;
        bus_if.reload = 1'b0;
`ifdef CAP_SENSOR_EN
        bus_if.tampa_ok = 1'b1;
`endif
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // First sealing with request held past completion.
        done_cyc = -1; pist_cnt = 0; disp_cnt = 0;
        bus_if.pos_ve = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            if (bus_if.ve_done && done_cyc < 0) done_cyc = n;
            if (bus_if.pistao) pist_cnt++;
            if (bus_if.dispensa) disp_cnt++;
        end
        check_val("done_latency", done_cyc, 18);
        check_val("pistao_len", pist_cnt, 12);
        check_val("single_feed", disp_cnt, 1);
        check_val("stock_after_1", int'(bus_if.estoque), 19);
        bus_if.pos_ve = 1'b0;
        step(); step();

        request(22, 2, 1'b0);
        check_val("stock_after_2", int'(bus_if.estoque), 18);

        // Abort during HOLD: no ve_done, cap not refunded.
        request(8, 8, 1'b0);
        check_val("stock_after_abort", int'(bus_if.estoque), 17);

        for (int k = 0; k < 25 && m_stock > 0; k++) request(20, 2, 1'b0);
        check_val("stock_empty", int'(bus_if.estoque), 0);
        bus_if.pos_ve = 1'b1;
        step(); step(); step();
        check_val("alarme_empty", int'(bus_if.alarme), 1);
        bus_if.reload = 1'b1;
        step();
        bus_if.reload = 1'b0;
        check_val("stock_reload", int'(bus_if.estoque), CAP_MAX);
        for (int i = 0; i < 22; i++) step();
        check_val("stock_after_reload", int'(bus_if.estoque), 19);
        bus_if.pos_ve = 1'b0;
        step(); step();

        // Asynchronous reset in the middle of DOWN.
        bus_if.pos_ve = 1'b1;
        step(); step(); step();
        check_val("pistao_pre_reset", int'(bus_if.pistao), 1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        bus_if.pos_ve = 1'b0;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        step();

`ifdef CAP_SENSOR_EN
        disp_cnt = 0; done_cyc = 0;
        bus_if.tampa_ok = 1'b0;
        bus_if.pos_ve = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step();
            if (bus_if.dispensa) disp_cnt++;
            if (bus_if.ve_done && bus_if.falha_ved) done_cyc++;
        end
        check_val("retry_feeds", disp_cnt, 2);
        check_val("falha_pulse", done_cyc, 1);
        check_val("stock_retry", int'(bus_if.estoque), 18);
        bus_if.pos_ve = 1'b0;
        bus_if.tampa_ok = 1'b1;
        step(); step();
`endif

        // Randomized requests of varied length with occasional reloads.
        for (int t = 0; t < 60; t++) begin
            request($urandom_range(1, 30), $urandom_range(1, 4), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
